pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (F/D/X/M/W).

---
 rtl/pipeline_stall_ctrl_if.sv | 35 +++
 rtl/pipeline_stall_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the hazard/multdiv sources and the stall controller.
// The controller drives pipeline-latch enables, bubble controls and status.
interface pipeline_stall_ctrl_if #(
  parameter int PERF_W = 16
);
  logic              hazard;
  logic              branch_x;
  logic              md_start_x;
  logic              md_ready;
  logic              pc_en;
  logic              fd_en;
  logic              dx_en;
  logic              xm_en;
  logic              mw_en;
  logic              fd_flush;
  logic              dx_bubble;
  logic              xm_bubble;
  logic              md_busy;
  logic              md_timeout;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output hazard, branch_x, md_start_x, md_ready,
    input  pc_en, fd_en, dx_en, xm_en, mw_en,
    input  fd_flush, dx_bubble, xm_bubble,
    input  md_busy, md_timeout, stall_cycles
  );

  modport slave (
    input  hazard, branch_x, md_start_x, md_ready,
    output pc_en, fd_en, dx_en, xm_en, mw_en,
    output fd_flush, dx_bubble, xm_bubble,
    output md_busy, md_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: zero-latency controls from state and inputs.
// Multi-cycle mult/div ops hold F/D/X until ready or a forced timeout release.
module pipeline_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pipeline_stall_ctrl_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic              lu_done_q, lu_done_d;
  logic              md_tmo_q, md_tmo_d;
  logic [PERF_W-1:0] stall_q;

  logic pc_en_c, fd_en_c, dx_en_c, xm_en_c, mw_en_c;
  logic fd_flush_c, dx_bubble_c, xm_bubble_c;

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    lu_done_d   = 1'b0;
    md_tmo_d    = 1'b0;
    pc_en_c     = 1'b1;
    fd_en_c     = 1'b1;
    dx_en_c     = 1'b1;
    xm_en_c     = 1'b1;
    mw_en_c     = 1'b1;
    fd_flush_c  = 1'b0;
    dx_bubble_c = 1'b0;
    xm_bubble_c = 1'b0;

    if (!reset_n) begin
      // Latches keep loading so the pipeline fills with NOPs during reset.
      fd_flush_c  = 1'b1;
      dx_bubble_c = 1'b1;
      xm_bubble_c = 1'b1;
      state_d     = RUN;
      md_cnt_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.branch_x) begin
            fd_flush_c  = 1'b1;
            dx_bubble_c = 1'b1;
          end else if (bus.md_start_x && !bus.md_ready) begin
            pc_en_c     = 1'b0;
            fd_en_c     = 1'b0;
            dx_en_c     = 1'b0;
            xm_bubble_c = 1'b1;
            state_d     = MD_WAIT;
            md_cnt_d    = CNT_W'(1);
          end else begin
            // Remembered while hazard stays high so the load-use stall is one cycle only.
            lu_done_d = bus.hazard;
            if (bus.hazard && !lu_done_q) begin
              pc_en_c     = 1'b0;
              fd_en_c     = 1'b0;
              dx_bubble_c = 1'b1;
            end
          end
        end
        MD_WAIT: begin
          if (bus.md_ready) begin
            state_d  = RUN;
            md_cnt_d = '0;
          end else begin
            pc_en_c     = 1'b0;
            fd_en_c     = 1'b0;
            dx_en_c     = 1'b0;
            xm_bubble_c = 1'b1;
            if (md_cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
              state_d  = RUN;
              md_cnt_d = '0;
              md_tmo_d = 1'b1;
            end else begin
              md_cnt_d = md_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= RUN;
      md_cnt_q  <= '0;
      lu_done_q <= 1'b0;
      md_tmo_q  <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      lu_done_q <= lu_done_d;
      md_tmo_q  <= md_tmo_d;
      if (!pc_en_c && (stall_q != {PERF_W{1'b1}})) begin
        stall_q <= stall_q + PERF_W'(1);
      end
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.fd_en        = fd_en_c;
  assign bus.dx_en        = dx_en_c;
  assign bus.xm_en        = xm_en_c;
  assign bus.mw_en        = mw_en_c;
  assign bus.fd_flush     = fd_flush_c;
  assign bus.dx_bubble    = dx_bubble_c;
  assign bus.xm_bubble    = xm_bubble_c;
  assign bus.md_busy      = (state_q == MD_WAIT);
  assign bus.md_timeout   = md_tmo_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl; a second small instance
// (PERF_W=4, MD_TIMEOUT=2) exercises counter saturation and the minimum timeout.
module tb_pipeline_stall_ctrl;

  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_RST = 8'b11111_111;
  localparam logic [7:0] C_BR  = 8'b11111_110;
  localparam logic [7:0] C_MD  = 8'b00011_001;
  localparam logic [7:0] C_LU  = 8'b00111_010;

  typedef struct {
    logic [7:0]  ctrl;
    logic        busy;
    logic        tmo;
    logic [15:0] stall;
    logic        chk_reg;
    string       tag;
  } exp_t;

  logic clock;
  logic rst_n;
  logic rst_s_n;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_stall = 16'd0;
  exp_t        sbq[$];

  pipeline_stall_ctrl_if #(.PERF_W(16)) m ();
  pipeline_stall_ctrl_if #(.PERF_W(4))  s ();

  pipeline_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6), .PERF_W(16)) dut (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (m.slave)
  );

  pipeline_stall_ctrl #(.MD_TIMEOUT(2), .CNT_W(2), .PERF_W(4)) dut_s (
    .clock   (clock),
    .reset_n (rst_s_n),
    .bus     (s.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] ctrl_of_m();
    return {m.pc_en, m.fd_en, m.dx_en, m.xm_en, m.mw_en, m.fd_flush, m.dx_bubble, m.xm_bubble};
  endfunction

  function automatic logic [7:0] ctrl_of_s();
    return {s.pc_en, s.fd_en, s.dx_en, s.xm_en, s.mw_en, s.fd_flush, s.dx_bubble, s.xm_bubble};
  endfunction

  // One clock cycle on the main instance: drive, enqueue expectation, compare at negedge.
  task automatic step(input logic r, input logic h, input logic b, input logic ms, input logic mr,
                      input logic [7:0] ctrl, input logic busy, input logic tmo,
                      input logic chk, input string tag);
    exp_t e;
    rst_n        = r;
    m.hazard     = h;
    m.branch_x   = b;
    m.md_start_x = ms;
    m.md_ready   = mr;
    e.ctrl = ctrl; e.busy = busy; e.tmo = tmo; e.stall = exp_stall; e.chk_reg = chk; e.tag = tag;
    sbq.push_back(e);
    @(negedge clock);
    e = sbq.pop_front();
    checks++;
    assert (ctrl_of_m() === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", e.tag, ctrl_of_m(), e.ctrl);
    end
    if (e.chk_reg) begin
      checks++;
      assert (m.md_busy === e.busy) else begin
        errors++;
        $error("FAIL %s md_busy observed=%b expected=%b", e.tag, m.md_busy, e.busy);
      end
      checks++;
      assert (m.md_timeout === e.tmo) else begin
        errors++;
        $error("FAIL %s md_timeout observed=%b expected=%b", e.tag, m.md_timeout, e.tmo);
      end
      checks++;
      assert (m.stall_cycles === e.stall) else begin
        errors++;
        $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, m.stall_cycles, e.stall);
      end
    end
    if (!r) exp_stall = 16'd0;
    else if (!e.ctrl[7] && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    exp_t e;
    rst_s_n = 1'b0;
    s.hazard = 1'b0; s.branch_x = 1'b0; s.md_start_x = 1'b0; s.md_ready = 1'b0;

    // T1 reset
    step(0, 0, 0, 0, 0, C_RST, 0, 0, 0, "t1_rst0");
    step(0, 0, 0, 0, 0, C_RST, 0, 0, 1, "t1_rst1");
    rst_s_n = 1'b1;
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t1_run");

    // T2 load-use held high: one stall only; re-arms after hazard drops
    step(1, 1, 0, 0, 0, C_LU,  0, 0, 1, "t2_lu_c1");
    step(1, 1, 0, 0, 0, C_RUN, 0, 0, 1, "t2_lu_c2");
    step(1, 1, 0, 0, 0, C_RUN, 0, 0, 1, "t2_lu_c3");
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t2_drop");
    step(1, 1, 0, 0, 0, C_LU,  0, 0, 1, "t2_rearm");
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t2_idle");

    // Single-cycle mult/div: no stall
    step(1, 0, 0, 1, 1, C_RUN, 0, 0, 1, "md_single");

    // T3 mult/div ready after 5 stall cycles; branch/hazard ignored while waiting
    step(1, 0, 0, 1, 0, C_MD,  0, 0, 1, "t3_c1");
    step(1, 0, 0, 1, 0, C_MD,  1, 0, 1, "t3_c2");
    step(1, 1, 1, 1, 0, C_MD,  1, 0, 1, "t3_c3_ignore");
    step(1, 0, 0, 1, 0, C_MD,  1, 0, 1, "t3_c4");
    step(1, 0, 0, 1, 0, C_MD,  1, 0, 1, "t3_c5");
    step(1, 0, 0, 1, 1, C_RUN, 1, 0, 1, "t3_ready");
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t3_after");

    // T4 timeout after 40 stall cycles
    step(1, 0, 0, 1, 0, C_MD, 0, 0, 1, "t4_start");
    for (int i = 0; i < 39; i++) step(1, 0, 0, 1, 0, C_MD, 1, 0, 1, "t4_wait");
    step(1, 0, 0, 0, 0, C_RUN, 0, 1, 1, "t4_pulse");
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t4_pulse_end");

    // T5 branch wins over hazard and over a mult/div start
    step(1, 1, 1, 0, 0, C_BR,  0, 0, 1, "t5_br_haz");
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t5_idle");
    step(1, 0, 1, 1, 0, C_BR,  0, 0, 1, "t5_br_md");
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t5_no_wait");

    // T6 reset during MD_WAIT aborts the wait
    step(1, 0, 0, 1, 0, C_MD,  0, 0, 1, "t6_c1");
    step(1, 0, 0, 1, 0, C_MD,  1, 0, 1, "t6_c2");
    step(0, 0, 0, 1, 0, C_RST, 1, 0, 1, "t6_rst");
    step(1, 0, 0, 0, 0, C_RUN, 0, 0, 1, "t6_run");
    step(1, 0, 0, 1, 1, C_RUN, 0, 0, 1, "t6_md_single");

    // Saturation and minimum timeout on the small instance: every cycle stalls
    s.md_start_x = 1'b1;
    for (int i = 0; i < 20; i++) begin
      e.ctrl    = C_MD;
      e.busy    = (i % 2 == 1);
      e.tmo     = (i >= 2) && (i % 2 == 0);
      e.stall   = (i > 15) ? 16'd15 : 16'(i);
      e.chk_reg = 1'b1;
      e.tag     = "sat";
      sbq.push_back(e);
      @(negedge clock);
      e = sbq.pop_front();
      checks++;
      assert (ctrl_of_s() === e.ctrl) else begin
        errors++;
        $error("FAIL %s[%0d] ctrl observed=%b expected=%b", e.tag, i, ctrl_of_s(), e.ctrl);
      end
      checks++;
      assert ({s.md_busy, s.md_timeout} === {e.busy, e.tmo}) else begin
        errors++;
        $error("FAIL %s[%0d] busy/tmo observed=%b%b expected=%b%b", e.tag, i,
               s.md_busy, s.md_timeout, e.busy, e.tmo);
      end
      checks++;
      assert (s.stall_cycles === e.stall[3:0]) else begin
        errors++;
        $error("FAIL %s[%0d] stall_cycles observed=%0d expected=%0d", e.tag, i,
               s.stall_cycles, e.stall[3:0]);
      end
      @(posedge clock);
      #1;
    end
    s.md_start_x = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
